mod_updown_counter: RTL and testbench

- Parametrised synchronous modulo-N up/down counter; next generation of the 4-bit ripple counter.
- Single clock domain, no ripple clocking.
- Adds enable, direction, synchronous clear, parallel load, wrap/saturate mode and terminal-count/overflow status.
- Used as a general timer/event counter in the digital blocks and as a prescaler building block.

---
 rtl/mod_updown_counter.sv | 103 ++++++++++
 tb/tb_mod_updown_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: synchronous modulo-MODULUS up/down counter with clear, load, wrap/saturate
// and status flags. Define MOD_COUNTER_COMPARE_EN to add the cmp_val/match comparator.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_COMPARE_EN
  input  logic [WIDTH-1:0] cmp_val,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_p,
  output logic             ovf
`ifdef MOD_COUNTER_COMPARE_EN
  ,
  output logic             match
`endif
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS=%0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
  end

  // Out-of-range load values clamp to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

  assign at_max = (q == MAX_Q);
  assign at_min = (q == '0);
  assign tc     = en & ((up & at_max) | (~up & at_min));

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    if (clr) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (load) begin
      q_nxt = clamp_load(load_val);
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          q_nxt = q + 1'b1;
        end else begin
          q_nxt    = (SATURATE != 0) ? MAX_Q : '0;
          wrap_nxt = 1'b1;
          ovf_nxt  = 1'b1;
        end
      end else begin
        if (!at_min) begin
          q_nxt = q - 1'b1;
        end else begin
          q_nxt    = (SATURATE != 0) ? '0 : MAX_Q;
          wrap_nxt = 1'b1;
          ovf_nxt  = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= '0;
      wrap_p <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      q      <= q_nxt;
      wrap_p <= wrap_nxt;
      ovf    <= ovf_nxt;
    end
  end

`ifdef MOD_COUNTER_COMPARE_EN
  // Compare against the next count so match lines up with the q it describes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match <= 1'b0;
    end else begin
      match <= (q_nxt == cmp_val);
    end
  end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed vector table plus hand sequences for saturation,
// power-of-2 modulus, asynchronous reset and the optional comparator.
module tb_mod_updown_counter;

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lv;
    logic       tc;
    logic [3:0] q;
    logic       wrap;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, clr, load;
  logic [3:0] load_val;
  logic [3:0] q_w, q_s, q_p;
  logic       tc_w, tc_s, tc_p;
  logic       wrap_w, wrap_s, wrap_p;
  logic       ovf_w, ovf_s, ovf_p;
`ifdef MOD_COUNTER_COMPARE_EN
  logic [3:0] cmp_val;
  logic       match_w, match_s, match_p;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_COMPARE_EN
    .cmp_val(cmp_val), .match(match_w),
`endif
    .q(q_w), .tc(tc_w), .wrap_p(wrap_w), .ovf(ovf_w));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_COMPARE_EN
    .cmp_val(cmp_val), .match(match_s),
`endif
    .q(q_s), .tc(tc_s), .wrap_p(wrap_s), .ovf(ovf_s));

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_p (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
`ifdef MOD_COUNTER_COMPARE_EN
    .cmp_val(cmp_val), .match(match_p),
`endif
    .q(q_p), .tc(tc_p), .wrap_p(wrap_p), .ovf(ovf_p));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u,
                       input logic [3:0] v);
    clr = c; load = l; en = e; up = u; load_val = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, (i == 9), 4'((i + 1) % 10), (i == 9), (i == 9)});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd8, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd13, 1'b0, 4'd9, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  1'b1, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  1'b0, 4'd9, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  1'b1, 4'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 4'd2, 1'b0, 1'b0});

    reset = 1'b0;
    drive(0, 0, 0, 0, 4'd0);
`ifdef MOD_COUNTER_COMPARE_EN
    cmp_val = 4'd5;
`endif
    #12;
    check("reset.q", q_w, 0);
    check("reset.wrap", wrap_w, 0);
    check("reset.ovf", ovf_w, 0);
    check("reset.tc", tc_w, 0);
    reset = 1'b1;

    // Table-driven vectors against the MODULUS=10 wrapping counter
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
      #1;
      check($sformatf("vec%0d.tc", i), tc_w, vecs[i].tc);
      tick();
      check($sformatf("vec%0d.q", i), q_w, vecs[i].q);
      check($sformatf("vec%0d.wrap", i), wrap_w, vecs[i].wrap);
      check($sformatf("vec%0d.ovf", i), ovf_w, vecs[i].ovf);
    end

    // Saturating counter held at its limits
    drive(1, 0, 0, 0, 4'd0); tick();
    check("sat.clr.q", q_s, 0);
    drive(0, 1, 0, 0, 4'd9); tick();
    check("sat.load.q", q_s, 9);
    check("sat.load.wrap", wrap_s, 0);
    drive(0, 0, 1, 1, 4'd0); #1;
    check("sat.tc", tc_s, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("sat.hold%0d.q", k), q_s, 9);
      check($sformatf("sat.hold%0d.wrap", k), wrap_s, 1);
      check($sformatf("sat.hold%0d.ovf", k), ovf_s, 1);
    end
    drive(1, 0, 0, 0, 4'd0); tick();
    check("sat.clr2.q", q_s, 0);
    check("sat.clr2.ovf", ovf_s, 0);
    check("sat.clr2.wrap", wrap_s, 0);
    drive(0, 0, 1, 0, 4'd0); tick();
    check("sat.dn.q", q_s, 0);
    check("sat.dn.wrap", wrap_s, 1);
    check("sat.dn.ovf", ovf_s, 1);
    drive(0, 0, 0, 0, 4'd0); tick();
    check("sat.idle.wrap", wrap_s, 0);
    check("sat.idle.ovf", ovf_s, 1);

    // Power-of-2 modulus: natural wrap
    drive(0, 1, 0, 0, 4'd15); tick();
    check("p2.load.q", q_p, 15);
    drive(0, 0, 1, 1, 4'd0); tick();
    check("p2.up.q", q_p, 0);
    check("p2.up.wrap", wrap_p, 1);
    check("p2.up.ovf", ovf_p, 1);
    drive(0, 0, 1, 0, 4'd0); tick();
    check("p2.dn.q", q_p, 15);
    check("p2.dn.wrap", wrap_p, 1);
    drive(0, 1, 0, 0, 4'd13); tick();
    check("p2.load13.q", q_p, 13);
    check("p2.load13.wrap", wrap_p, 0);

    // Asynchronous reset mid-count
    drive(0, 1, 0, 0, 4'd9); tick();
    drive(0, 0, 1, 1, 4'd0); tick();
    check("ar.wrap.q", q_w, 0);
    check("ar.wrap.ovf", ovf_w, 1);
    repeat (6) tick();
    check("ar.pre.q", q_w, 6);
    #3 reset = 1'b0;
    #1;
    check("ar.async.q", q_w, 0);
    check("ar.async.ovf", ovf_w, 0);
    check("ar.async.wrap", wrap_w, 0);
    tick();
    check("ar.held.q", q_w, 0);
    reset = 1'b1;
    tick();
    check("ar.release.q", q_w, 1);

`ifdef MOD_COUNTER_COMPARE_EN
    drive(1, 0, 0, 0, 4'd0); tick();
    check("cmp.clr.match", match_w, 0);
    for (int k = 1; k <= 7; k++) begin
      drive(0, 0, 1, 1, 4'd0); tick();
      check($sformatf("cmp.cnt%0d.q", k), q_w, k);
      check($sformatf("cmp.cnt%0d.match", k), match_w, (k == 5));
    end
    drive(0, 1, 0, 0, 4'd5); tick();
    check("cmp.load.q", q_w, 5);
    check("cmp.load.match", match_w, 1);
    drive(1, 0, 0, 0, 4'd0); tick();
    check("cmp.clr2.match", match_w, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
